keccak_out_arbiter: RTL and testbench
=====================================

# keccak_out_arbiter

Round-robin controller that shares one `keccak_buffer_out` instance between `N_REQ` digest producers (Keccak cores or hash channels). It accepts one 256-bit digest at a time from a requester and loads it into the output buffer with a single-cycle `input_valid` pulse. It then gates the buffer's word-by-word drain to the downstream consumer and tags each word with the source ID and a last-word flag. It sits between the Keccak cores and `keccak_buffer_out`, and owns that buffer's `input_valid`/`output_ready` handshake.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters; legal range 2..8.
- `DIGEST_BITS`, default 256: digest width; must be a multiple of `OUT_BUF_SIZE`.
- `ID_W`, default `$clog2(N_REQ)`: width of the source tag.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a digest available.
- `req_digest`  in  N_REQ×DIGEST_BITS  packed digests; requester i occupies slice i.
- `req_ready`  out  N_REQ  one-hot; digest i is accepted in the cycle where `req_valid[i] && req_ready[i]`.
- `buf_input`  out  DIGEST_BITS  digest to the buffer (`buffer_input`).
- `buf_input_valid`  out  1  load pulse to the buffer (`input_valid`).
- `buf_output_valid`  in  1  buffer word valid (`buffer_output_valid`).
- `buf_output_ready`  out  1  drives the buffer's `output_ready`.
- `down_ready`  in  1  downstream can take a word.
- `down_valid`  out  1  word valid toward downstream; buffer data goes to downstream directly.
- `down_id`  out  ID_W  source of the current word.
- `down_last`  out  1  current word is the final word of the digest.

## Operation
- `OUT_WORDS = DIGEST_BITS/OUT_BUF_SIZE`; the default is 4.
- The state machine is `IDLE → LOAD → DRAIN → IDLE`.
- **IDLE:**
  - The picker chooses the first requester with `req_valid` at or after `rr_ptr`.
  - In the same cycle, `req_ready[g]` is asserted combinationally.
  - `req_digest[g]` is captured into `buf_input` and `g` is captured into `grant_id`; the state moves to LOAD.
  - If no requester is valid, the block stays in IDLE.
- **LOAD:** `buf_input_valid` is high for exactly this one cycle, then the state moves to DRAIN.
- **DRAIN:**
  - `buf_output_ready = down_ready`, `down_valid = buf_output_valid`, and `down_id = grant_id`.
  - `word_cnt` increments on each `buf_output_valid && down_ready`.
  - `down_last = (word_cnt == OUT_WORDS-1)`.
  - On a handshake while `down_last` is high:
    - `rr_ptr` becomes `grant_id+1`, wrapping modulo `N_REQ`.
    - `word_cnt` is cleared.
    - The state moves to IDLE.
- Outside DRAIN:
  - `buf_output_ready`, `down_valid` and `down_last` are 0.
  - A stray `buf_output_valid` is ignored and not counted.
- `buf_input` holds its value until the next accept.
- `req_ready` is 0 in LOAD and DRAIN.
- Simultaneous requests are served in round-robin order. A requester that is held valid is re-served only after every other valid requester has been served.
- The picker is purely combinational. `rr_ptr` is `ID_W` bits wide.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `word_cnt`=0, `grant_id`=0, `buf_input`=0. All outputs are 0.
- Reset asserted mid-DRAIN aborts the digest immediately. The buffer is reset from the same net.
- Accept at cycle T, `buf_input_valid` at T+1, first possible word at T+2.
- Minimum digest period is `OUT_WORDS+2` cycles, including a one-cycle IDLE bubble between digests.
- `down_ready` low stalls DRAIN indefinitely without losing the count.

## Configuration
- `KECCAK_ARB_STATS_EN` defined:
  - Adds output `stat_count`, `N_REQ`×16 bits.
  - Entry i increments on each completed last-word handshake for ID i.
  - Each entry saturates at 16'hFFFF.
  - Entries reset to 0.
- Undefined: the port, the counters and their logic are absent, with no other behavioural difference.

## Structure
- `pkg_keccak` gains:
  - `DIGEST_BITS` (256).
  - `OUT_WORDS`.
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_LOAD, ARB_DRAIN} arb_state_t`.
- Uses the existing `OUT_BUF_SIZE`.
- One sub-module, `keccak_rr_pick`:
  - Combinational.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: one-hot grant and `any_valid`.

## Test plan
- Reset: hold reset low 3 cycles with `req_valid`=2'b11 → all outputs 0, no `req_ready`; after release, req0 is granted first.
- Single request: req0 with digest 256'h852fbe38…bb23dc25, `down_ready`=1 → `buf_input_valid` pulses at T+1; 4 words with `down_id`=0; `down_last` only on the 4th word; return to IDLE.
- Contention: `req_valid`=2'b11 held → grant order 0,1,0,1; each digest has exactly 4 tagged words.
- Backpressure: `down_ready` toggles 1,0,0,1 during DRAIN → `word_cnt` advances only on handshakes; `buf_output_ready` mirrors `down_ready`.
- Reset mid-DRAIN after 2 words → IDLE, `rr_ptr`=0, next digest starts at word 0.
- With `KECCAK_ARB_STATS_EN`: 3 digests from req1 → `stat_count[1]`=3, `stat_count[0]`=0.

Source files
------------

// File: rtl/pkg_keccak.sv
// Shared Keccak constants and the output-arbiter state type.
package pkg_keccak;

    localparam int OUT_BUF_SIZE = 64;
    localparam int DIGEST_BITS  = 256;
    localparam int OUT_WORDS    = DIGEST_BITS / OUT_BUF_SIZE;

    typedef enum logic [1:0] {ARB_IDLE, ARB_LOAD, ARB_DRAIN} arb_state_t;

endpackage

// File: rtl/keccak_out_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first valid requester at or
// after rr_ptr, wrapping modulo N_REQ.
module keccak_rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic             any_valid
);

    int idx;

    // Walk from the farthest offset back to rr_ptr so the nearest valid wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (req_valid[ID_W'(idx)]) begin
                grant              = '0;
                grant[ID_W'(idx)]  = 1'b1;
            end
        end
        any_valid = |req_valid;
    end

endmodule

// File: rtl/keccak_out_arbiter.sv
// Shares one keccak_buffer_out between N_REQ digest producers: accept one
// digest, pulse the buffer load, then gate the word drain downstream with a
// source tag and last-word flag.
// Optional: define KECCAK_ARB_STATS_EN to add saturating per-source digest
// counters on stat_count.
module keccak_out_arbiter #(
    parameter int N_REQ       = 2,
    parameter int DIGEST_BITS = 256,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ-1:0][DIGEST_BITS-1:0] req_digest,
    output logic [N_REQ-1:0]                  req_ready,
    output logic [DIGEST_BITS-1:0]            buf_input,
    output logic                              buf_input_valid,
    input  logic                              buf_output_valid,
    output logic                              buf_output_ready,
    input  logic                              down_ready,
    output logic                              down_valid,
    output logic [ID_W-1:0]                   down_id,
    output logic                              down_last
`ifdef KECCAK_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][15:0]            stat_count
`endif
);
    import pkg_keccak::*;

    localparam int WORDS = DIGEST_BITS / OUT_BUF_SIZE;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    arb_state_t       state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, grant_id, pick_id;
    logic [CNT_W-1:0] word_cnt;
    logic [N_REQ-1:0] pick_gnt;
    logic             any_valid, accept, hs;

    keccak_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_gnt),
        .any_valid (any_valid)
    );

    // Encode the one-hot pick into an index for capture and tagging.
    always_comb begin
        pick_id = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick_gnt[i]) pick_id = ID_W'(i);
    end

    assign accept    = (state == ARB_IDLE) && any_valid;
    // Gated by reset so no requester sees a ready while the block is held.
    assign req_ready = ((state == ARB_IDLE) && reset) ? pick_gnt : '0;
    assign down_id   = (state == ARB_DRAIN) ? grant_id : '0;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    // Next state and buffer/downstream handshake gating.
    always_comb begin
        state_nxt        = state;
        buf_input_valid  = 1'b0;
        buf_output_ready = 1'b0;
        down_valid       = 1'b0;
        down_last        = 1'b0;
        hs               = 1'b0;
        case (state)
            ARB_IDLE: if (any_valid) state_nxt = ARB_LOAD;
            ARB_LOAD: begin
                buf_input_valid = 1'b1;
                state_nxt       = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                buf_output_ready = down_ready;
                down_valid       = buf_output_valid;
                down_last        = (word_cnt == CNT_W'(WORDS - 1));
                hs               = buf_output_valid && down_ready;
                if (hs && down_last) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Digest capture, word counting and round-robin pointer advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_input <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            word_cnt  <= '0;
        end else begin
            if (accept) begin
                buf_input <= req_digest[pick_id];
                grant_id  <= pick_id;
            end
            if (hs) begin
                if (down_last) begin
                    word_cnt <= '0;
                    rr_ptr   <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                end else begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef KECCAK_ARB_STATS_EN
    // Saturating count of completed digests per source.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_count <= '0;
        end else if (hs && down_last && stat_count[grant_id] != 16'hFFFF) begin
            stat_count[grant_id] <= stat_count[grant_id] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_keccak_out_arbiter.sv
// Bench for keccak_out_arbiter with a behavioural output-buffer model and a
// round-robin reference built from the grant rules.
module tb_keccak_out_arbiter;

    localparam int N  = 2;
    localparam int DB = 256;
    localparam int WB = 64;
    localparam int W  = DB / WB;
    localparam int IW = 1;

    logic               clock, reset;
    logic [N-1:0]       req_valid;
    logic [N-1:0][DB-1:0] req_digest;
    logic [N-1:0]       req_ready;
    logic [DB-1:0]      buf_input;
    logic               buf_input_valid, buf_output_valid, buf_output_ready;
    logic               down_ready, down_valid, down_last;
    logic [IW-1:0]      down_id;
`ifdef KECCAK_ARB_STATS_EN
    logic [N-1:0][15:0] stat_count;
`endif

    keccak_out_arbiter #(.N_REQ(N), .DIGEST_BITS(DB)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_digest       (req_digest),
        .req_ready        (req_ready),
        .buf_input        (buf_input),
        .buf_input_valid  (buf_input_valid),
        .buf_output_valid (buf_output_valid),
        .buf_output_ready (buf_output_ready),
        .down_ready       (down_ready),
        .down_valid       (down_valid),
        .down_id          (down_id),
        .down_last        (down_last)
`ifdef KECCAK_ARB_STATS_EN
        ,
        .stat_count       (stat_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output buffer model: loads on the pulse, shifts out low word first.
    logic [DB-1:0] bq;
    int            bcnt;
    logic          stray;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcnt <= 0;
            bq   <= '0;
        end else if (buf_input_valid) begin
            bq   <= buf_input;
            bcnt <= W;
        end else if (buf_output_valid && buf_output_ready) begin
            bq   <= bq >> WB;
            bcnt <= bcnt - 1;
        end
    end
    assign buf_output_valid = (bcnt > 0) || stray;

    int n_cmp = 0;
    int n_fail = 0;
    int m_ptr = 0;
    int m_stats [N];

    task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DB-1:0] r256();
        logic [DB-1:0] v = '0;
        for (int i = 0; i < DB / 32; i++) v = {v[DB-33:0], 32'($urandom())};
        return v;
    endfunction

    // Reference pick: first set bit at or after the pointer, wrapping.
    function automatic int exp_pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_rdy"},  256'(req_ready),        256'(0));
        check({tag, "_biv"},  256'(buf_input_valid),  256'(0));
        check({tag, "_bor"},  256'(buf_output_ready), 256'(0));
        check({tag, "_dv"},   256'(down_valid),       256'(0));
        check({tag, "_dl"},   256'(down_last),        256'(0));
        check({tag, "_did"},  256'(down_id),          256'(0));
        check({tag, "_bin"},  buf_input,              256'(0));
    endtask

    // One digest: mode 0 always ready, 1 random ready, 2 ready pattern 1,0,0,1.
    // abort_at >= 0 asserts reset once that many words have been taken.
    task automatic do_digest(input logic [N-1:0] mask, input int mode, input int abort_at);
        int            g, w, cyc, p;
        logic          dr;
        logic [N-1:0]  oh;
        logic [DB-1:0] d;
        logic [3:0]    pat;
        pat = 4'b1001;
        g = exp_pick(mask);
        d = req_digest[g];
        oh = '0;
        oh[g] = 1'b1;
        req_valid  = mask;
        down_ready = 1'b0;
        #1;
        check("req_ready", 256'(req_ready), 256'(oh));
        @(posedge clock); #1;
        check("load_pulse", 256'(buf_input_valid), 256'(1));
        check("load_data", buf_input, d);
        check("ready_in_load", 256'(req_ready), 256'(0));
        check("dv_in_load", 256'(down_valid), 256'(0));
        req_digest[g] = r256();
        @(posedge clock); #1;
        w = 0; cyc = 0; p = 0;
        while (w < W && cyc < 200) begin
            if (w == abort_at) begin
                reset = 1'b0;
                #1;
                check_quiet("abort");
                req_valid = '0;
                @(posedge clock); @(posedge clock); #1;
                reset = 1'b1;
                m_ptr = 0;
                for (int i = 0; i < N; i++) m_stats[i] = 0;
                return;
            end
            case (mode)
                0:       dr = 1'b1;
                1:       dr = 1'($urandom_range(1, 0));
                default: dr = pat[3 - (p % 4)];
            endcase
            p++;
            down_ready = dr;
            #1;
            check("bor_mirror", 256'(buf_output_ready), 256'(dr));
            check("dvalid", 256'(down_valid), 256'(1));
            check("did", 256'(down_id), 256'(g));
            check("dlast", 256'(down_last), 256'(w == W - 1));
            check("dword", 256'(bq[WB-1:0]), 256'(d[w*WB +: WB]));
            @(posedge clock); #1;
            if (dr) w++;
            cyc++;
        end
        if (w < W) begin
            n_cmp++;
            n_fail++;
            $error("FAIL drain_timeout: observed %0d words expected %0d", w, W);
        end else begin
            m_ptr = (g + 1) % N;
            if (m_stats[g] < 65535) m_stats[g]++;
        end
        down_ready = 1'b0;
        #1;
        check("idle_dv", 256'(down_valid), 256'(0));
        check("idle_dl", 256'(down_last), 256'(0));
    endtask

    initial begin
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m_stats[i] = 0;
        stray      = 1'b0;
        down_ready = 1'b0;
        reset      = 1'b0;
        req_valid  = 2'b11;
        req_digest[0] = 256'h852fbe38_9a1c44e0_5d7310ab_c2e6f9d4_0b81a7c3_64d2e519_f3a08b67_bb23dc25;
        req_digest[1] = r256();

        // Held in reset with both requesting: everything quiet.
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            check_quiet("reset");
        end
        reset = 1'b1;

        // First grant after reset goes to req0, then alternates under contention.
        do_digest(2'b11, 0, -1);
        do_digest(2'b11, 0, -1);
        do_digest(2'b11, 0, -1);
        do_digest(2'b11, 0, -1);

        // Stray buffer valid outside DRAIN is ignored and not counted.
        req_valid  = '0;
        stray      = 1'b1;
        down_ready = 1'b1;
        #1;
        check("stray_dv", 256'(down_valid), 256'(0));
        check("stray_bor", 256'(buf_output_ready), 256'(0));
        @(posedge clock); @(posedge clock); #1;
        stray      = 1'b0;
        down_ready = 1'b0;

        // Backpressure pattern, then abort a req1 digest mid-drain.
        do_digest(2'b11, 2, -1);
        do_digest(2'b10, 0, 2);
        do_digest(2'b11, 0, -1);

        // Repeated single-source digests.
        for (int i = 0; i < 3; i++) do_digest(2'b10, 0, -1);

        // Randomized masks and backpressure.
        for (int i = 0; i < 20; i++) begin
            m = 2'($urandom_range(3, 1));
            do_digest(m, 1, -1);
        end

`ifdef KECCAK_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("stat_count", 256'(stat_count[i]), 256'(m_stats[i]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
